// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared retirement types for the core and its trace consumer
package core_types_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        mem_wrt;
    } retire_entry_t;

    localparam int ENTRY_W = $bits(retire_entry_t);

endpackage

// File: rtl/trace_fifo_mem.sv
// rtl/trace_fifo_mem.sv - DEPTH-entry trace storage, two write ports, one combinational read port
module trace_fifo_mem
    import core_types_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wa_en,
    input  logic [PTR_W-1:0]   wa_addr,
    input  logic [ENTRY_W-1:0] wa_data,
    input  logic               wb_en,
    input  logic [PTR_W-1:0]   wb_addr,
    input  logic [ENTRY_W-1:0] wb_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    // The two ports never target the same slot: B always lands one past A.
    always_comb begin
        mem_d = mem_q;
        if (wa_en) mem_d[wa_addr] = wa_data;
        if (wb_en) mem_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - dual-lane retirement capture FIFO with sequence tags and drop accounting
// Optional NOP filtering when RETIRE_TRACE_FILTER_NOP_EN is defined.
module retire_trace_buffer
    import core_types_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid_a,
    input  logic [31:0]      retire_pc_a,
    input  logic [31:0]      retire_inst_a,
    input  logic [4:0]       retire_reg_addr_a,
    input  logic [31:0]      retire_reg_data_a,
    input  logic [31:0]      retire_mem_addr_a,
    input  logic [31:0]      retire_mem_data_a,
    input  logic             retire_mem_wrt_a,
    input  logic             retire_valid_b,
    input  logic [31:0]      retire_pc_b,
    input  logic [31:0]      retire_inst_b,
    input  logic [4:0]       retire_reg_addr_b,
    input  logic [31:0]      retire_reg_data_b,
    input  logic [31:0]      retire_mem_addr_b,
    input  logic [31:0]      retire_mem_data_b,
    input  logic             retire_mem_wrt_b,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_seq,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_inst,
    output logic [4:0]       trace_reg_addr,
    output logic [31:0]      trace_reg_data,
    output logic [31:0]      trace_mem_addr,
    output logic [31:0]      trace_mem_data,
    output logic             trace_mem_wrt,
    output logic [PTR_W:0]   fill_count,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fill_count_q, fill_count_d, free;
    logic [31:0]      seq_ctr_q, seq_ctr_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic [16:0]      drop_sum;
    logic             want_a, want_b, push_a, push_b, drop_a, drop_b, pop;
    retire_entry_t    entry_a, entry_b, head;
    logic [ENTRY_W-1:0] head_bits;

`ifdef RETIRE_TRACE_FILTER_NOP_EN
    assign want_a = retire_valid_a && (retire_inst_a != RV_NOP);
    assign want_b = retire_valid_b && (retire_inst_b != RV_NOP);
`else
    assign want_a = retire_valid_a;
    assign want_b = retire_valid_b;
`endif

    assign free        = DEPTH_C - fill_count_q;
    assign trace_valid = (fill_count_q != '0);
    assign pop         = trace_valid && trace_ready;

    // Capacity is judged on the start-of-cycle count; a same-cycle pop gives no credit.
    always_comb begin
        push_a = 1'b0;
        push_b = 1'b0;
        if (free >= (PTR_W+1)'(2)) begin
            push_a = want_a;
            push_b = want_b;
        end else if (free == (PTR_W+1)'(1)) begin
            push_a = want_a;
            push_b = want_b && !want_a;
        end
        drop_a = want_a && !push_a;
        drop_b = want_b && !push_b;
    end

    always_comb begin
        entry_a          = '0;
        entry_a.seq      = seq_ctr_q;
        entry_a.pc       = retire_pc_a;
        entry_a.inst     = retire_inst_a;
        entry_a.reg_addr = retire_reg_addr_a;
        entry_a.reg_data = retire_reg_data_a;
        entry_a.mem_addr = retire_mem_addr_a;
        entry_a.mem_data = retire_mem_data_a;
        entry_a.mem_wrt  = retire_mem_wrt_a;
        entry_b          = '0;
        entry_b.seq      = seq_ctr_q + 32'(retire_valid_a);
        entry_b.pc       = retire_pc_b;
        entry_b.inst     = retire_inst_b;
        entry_b.reg_addr = retire_reg_addr_b;
        entry_b.reg_data = retire_reg_data_b;
        entry_b.mem_addr = retire_mem_addr_b;
        entry_b.mem_data = retire_mem_data_b;
        entry_b.mem_wrt  = retire_mem_wrt_b;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        fill_count_d = fill_count_q + (PTR_W+1)'(push_a) + (PTR_W+1)'(push_b) - (PTR_W+1)'(pop);
        // Sequence advances for every valid lane, dropped or filtered, so gaps expose losses.
        seq_ctr_d    = seq_ctr_q + 32'(retire_valid_a) + 32'(retire_valid_b);
        overflow_d   = overflow_q || drop_a || drop_b;
        drop_sum     = {1'b0, drop_count_q} + 17'(drop_a) + 17'(drop_b);
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_count_q <= '0;
            seq_ctr_q    <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_count_q <= fill_count_d;
            seq_ctr_q    <= seq_ctr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wa_en   (push_a),
        .wa_addr (wr_ptr_q),
        .wa_data (entry_a),
        .wb_en   (push_b),
        .wb_addr (wr_ptr_q + PTR_W'(push_a)),
        .wb_data (entry_b),
        .rd_addr (rd_ptr_q),
        .rd_data (head_bits)
    );

    assign head           = retire_entry_t'(head_bits);
    assign trace_seq      = head.seq;
    assign trace_pc       = head.pc;
    assign trace_inst     = head.inst;
    assign trace_reg_addr = head.reg_addr;
    assign trace_reg_data = head.reg_data;
    assign trace_mem_addr = head.mem_addr;
    assign trace_mem_data = head.mem_data;
    assign trace_mem_wrt  = head.mem_wrt;
    assign fill_count     = fill_count_q;
    assign overflow       = overflow_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - scoreboard bench for retire_trace_buffer
module tb_retire_trace_buffer;
    import core_types_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        va, vb, mwa, mwb, trace_ready;
    logic [31:0] pca, pcb, ia, ib, rda, rdb, maa, mab, mda, mdb;
    logic [4:0]  raa, rab;
    logic        trace_valid, trace_mem_wrt, overflow;
    logic [31:0] trace_seq, trace_pc, trace_inst, trace_reg_data, trace_mem_addr, trace_mem_data;
    logic [4:0]  trace_reg_addr;
    logic [4:0]  fill_count;
    logic [15:0] drop_count;

    int n_vec = 0;
    int n_miss = 0;
    logic [31:0] exp_seq;
    retire_entry_t exp_q[$];

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .retire_valid_a(va), .retire_pc_a(pca), .retire_inst_a(ia), .retire_reg_addr_a(raa),
        .retire_reg_data_a(rda), .retire_mem_addr_a(maa), .retire_mem_data_a(mda), .retire_mem_wrt_a(mwa),
        .retire_valid_b(vb), .retire_pc_b(pcb), .retire_inst_b(ib), .retire_reg_addr_b(rab),
        .retire_reg_data_b(rdb), .retire_mem_addr_b(mab), .retire_mem_data_b(mdb), .retire_mem_wrt_b(mwb),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_seq(trace_seq), .trace_pc(trace_pc),
        .trace_inst(trace_inst), .trace_reg_data(trace_reg_data), .trace_mem_addr(trace_mem_addr),
        .trace_mem_data(trace_mem_data), .trace_reg_addr(trace_reg_addr), .trace_mem_wrt(trace_mem_wrt),
        .fill_count(fill_count), .overflow(overflow), .drop_count(drop_count)
    );

    function automatic retire_entry_t mk(input logic [31:0] seq, input logic [31:0] pc, input logic [31:0] inst);
        retire_entry_t e;
        e.seq      = seq;
        e.pc       = pc;
        e.inst     = inst;
        e.reg_addr = pc[6:2];
        e.reg_data = pc ^ 32'hA5A5_0000;
        e.mem_addr = pc + 32'h40;
        e.mem_data = ~pc;
        e.mem_wrt  = pc[2];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare the head against the oldest expected entry whenever a pop is presented.
    always @(negedge clk) begin
        if (!reset && trace_valid && trace_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_entry: got seq %h pc %h, expected none", trace_seq, trace_pc);
            end else begin
                retire_entry_t e;
                retire_entry_t a;
                e = exp_q.pop_front();
                a = '{trace_seq, trace_pc, trace_inst, trace_reg_addr, trace_reg_data,
                      trace_mem_addr, trace_mem_data, trace_mem_wrt};
                if (a !== e) begin
                    n_miss++;
                    $display("FAIL entry: got seq %h pc %h inst %h, expected seq %h pc %h inst %h",
                             a.seq, a.pc, a.inst, e.seq, e.pc, e.inst);
                end
            end
        end
    end

    task automatic lane_cycle(input logic a_v, input logic [31:0] a_pc, input logic [31:0] a_inst, input logic a_acc,
                              input logic b_v, input logic [31:0] b_pc, input logic [31:0] b_inst, input logic b_acc);
        retire_entry_t ea;
        retire_entry_t eb;
        ea = mk(exp_seq, a_pc, a_inst);
        eb = mk(exp_seq + 32'(a_v), b_pc, b_inst);
        exp_seq = exp_seq + 32'(a_v) + 32'(b_v);
        va = a_v; pca = ea.pc; ia = ea.inst; raa = ea.reg_addr; rda = ea.reg_data;
        maa = ea.mem_addr; mda = ea.mem_data; mwa = ea.mem_wrt;
        vb = b_v; pcb = eb.pc; ib = eb.inst; rab = eb.reg_addr; rdb = eb.reg_data;
        mab = eb.mem_addr; mdb = eb.mem_data; mwb = eb.mem_wrt;
        if (a_acc) exp_q.push_back(ea);
        if (b_acc) exp_q.push_back(eb);
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0;
    endtask

    task automatic dual(input logic [31:0] pc);
        lane_cycle(1'b1, pc, pc | 32'h33, 1'b1, 1'b1, pc + 32'h4, pc | 32'h37, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_seq = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        trace_ready = 1'b1;
        for (int i = 0; i < 200 && trace_valid; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_drained"}, {31'b0, trace_valid}, 32'd0);
        check({name, "_queue_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; trace_ready = 1'b0; va = 1'b0; vb = 1'b0; exp_seq = '0;
        {pca, pcb, ia, ib, rda, rdb, maa, mab, mda, mdb} = '0;
        {raa, rab, mwa, mwb} = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_valid", {31'b0, trace_valid}, 32'd0);
        check("rst_fill", {27'b0, fill_count}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_drops", {16'b0, drop_count}, 32'd0);
        check("rst_pc", trace_pc, 32'd0);
        check("rst_seq", trace_seq, 32'd0);

        // Dual retire with the sink always ready: fill grows 2, 3, 4.
        trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) dual(32'h1000 + 32'(i) * 32'h10);
        check("dual_fill", {27'b0, fill_count}, 32'd4);
        wait_drain("dual");

        // Lane B alone.
        do_reset();
        lane_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h0010_0113, 1'b1);
        check("bonly_fill", {27'b0, fill_count}, 32'd1);
        wait_drain("bonly");

        // Fill to DEPTH, then a fully dropped pair, then resume at seq 18.
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) dual(32'h2000 + 32'(i) * 32'h8);
        check("full_fill", {27'b0, fill_count}, 32'd16);
        check("full_overflow", {31'b0, overflow}, 32'd0);
        lane_cycle(1'b1, 32'h2100, 32'h13, 1'b0, 1'b1, 32'h2104, 32'h33, 1'b0);
        check("drop_overflow", {31'b0, overflow}, 32'd1);
        check("drop_count2", {16'b0, drop_count}, 32'd2);
        check("drop_fill", {27'b0, fill_count}, 32'd16);
        wait_drain("full");
        dual(32'h2200);
        wait_drain("resume");

        // One free slot with a simultaneous pop: A kept, B dropped.
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 7; i++) dual(32'h3000 + 32'(i) * 32'h8);
        lane_cycle(1'b1, 32'h3100, 32'h33, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check("one_free_fill", {27'b0, fill_count}, 32'd15);
        trace_ready = 1'b1;
        lane_cycle(1'b1, 32'h3200, 32'h33, 1'b1, 1'b1, 32'h3204, 32'h37, 1'b0);
        check("one_free_fill_after", {27'b0, fill_count}, 32'd15);
        check("one_free_drops", {16'b0, drop_count}, 32'd1);
        wait_drain("one_free");

        // Write pointer is 0 here; 15 more pushes bring it to 15, then a pair straddles the wrap.
        for (int i = 0; i < 7; i++) dual(32'h4000 + 32'(i) * 32'h8);
        lane_cycle(1'b1, 32'h4100, 32'h33, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_drain("pre_wrap");
        dual(32'h4200);
        check("wrap_fill", {27'b0, fill_count}, 32'd2);
        wait_drain("wrap");
        check("wrap_drops", {16'b0, drop_count}, 32'd1);

        // NOP handling, then reset asserted mid-drain.
        do_reset();
        trace_ready = 1'b0;
`ifdef RETIRE_TRACE_FILTER_NOP_EN
        lane_cycle(1'b1, 32'h5000, RV_NOP, 1'b0, 1'b1, 32'h5004, 32'h0050_0093, 1'b1);
        check("nop_fill", {27'b0, fill_count}, 32'd1);
`else
        lane_cycle(1'b1, 32'h5000, RV_NOP, 1'b1, 1'b1, 32'h5004, 32'h0050_0093, 1'b1);
        check("nop_fill", {27'b0, fill_count}, 32'd2);
`endif
        check("nop_drops", {16'b0, drop_count}, 32'd0);
        dual(32'h5100);
        trace_ready = 1'b1;
        @(posedge clk); #3;
        reset = 1'b1;
        exp_q.delete();
        exp_seq = '0;
        #1;
        check("midrst_valid", {31'b0, trace_valid}, 32'd0);
        check("midrst_fill", {27'b0, fill_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("postrst_pc", trace_pc, 32'd0);
        check("postrst_overflow", {31'b0, overflow}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("final_queue", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
